detect_event_logger: RTL and testbench
======================================

// Module: detect_event_logger
//
// PURPOSE
//   Downstream consumer of the serial pattern detector's 'detected' strobe.
//   - Timestamps every detection against a free-running cycle counter.
//   - Buffers timestamps in a small FIFO, drained over a valid/ready interface.
//   - Keeps saturating totals of captured and dropped events for status readout.
//
// PARAMETERS
//   TS_W   16  timestamp counter width (bits); wraps modulo 2^TS_W
//   DEPTH  8   FIFO depth in entries; power of two, >= 2
//   CNT_W  16  width of event_count and drop_count (saturating)
//
// PORTS
//   clk          in   1                 single clock, rising edge
//   rst          in   1                 synchronous reset, active-high
//   detected     in   1                 detector strobe; 1 cycle high = 1 event
//   enable       in   1                 1 = capture events; 0 = ignore detected
//   clear        in   1                 synchronous soft clear (see BEHAVIOUR)
//   ev_valid     out  1                 FIFO head holds a timestamp
//   ev_ready     in   1                 consumer accepts the head this cycle
//   ev_ts        out  TS_W              timestamp at FIFO head
//   fifo_level   out  $clog2(DEPTH)+1   entries held, 0..DEPTH
//   event_count  out  CNT_W             events written into the FIFO
//   drop_count   out  CNT_W             events lost because the FIFO was full
//   overflow     out  1                 sticky; set on first drop
//
// BEHAVIOUR
//   Reset (rst=1 at a clk edge), all registers go to 0 on that edge:
//     - ts counter, FIFO pointers, fifo_level, event_count, drop_count, overflow.
//     - ev_valid=0; ev_ts=0 (don't-care while ev_valid=0).
//     - rst overrides clear, enable and any handshake in the same cycle.
//     - Mid-stream reset discards all buffered entries.
//   Timestamp:
//     - ts increments by 1 every cycle rst=0, independent of enable and clear.
//     - Wraps 2^TS_W-1 -> 0 with no flag.
//   Event:
//     - Event = cycle where detected=1 and enable=1. The stored value is ts
//       in that same cycle, before its increment.
//     - Back-to-back detected=1 cycles are separate events.
//   Push/pop:
//     - Pop = ev_valid & ev_ready; the head advances on that edge.
//     - Push is accepted if level<DEPTH, or if level==DEPTH and pop occurs the
//       same cycle.
//     - Push and pop in the same cycle leave the level unchanged.
//     - Pop with level 0 cannot occur because ev_valid=0.
//   Latency:
//     - Event in cycle N into an empty FIFO gives ev_valid=1 in cycle N+1,
//       with ev_ts = ts(N).
//     - ev_ts/ev_valid are driven from registers or RAM head, not from detected.
//   Ordering: strict FIFO order. Pointers wrap modulo DEPTH.
//   Handshake rule: while ev_valid=1 and ev_ready=0, ev_ts is held stable.
//   Event accepted into the FIFO:
//     - event_count += 1, saturating at 2^CNT_W-1.
//   Event refused (full, no same-cycle pop):
//     - Entry not written.
//     - drop_count += 1, saturating at 2^CNT_W-1.
//     - overflow <= 1.
//   Clear (clear=1, rst=0):
//     - Empties the FIFO; zeroes event_count, drop_count and overflow.
//     - An event in the clear cycle is discarded and not counted.
//     - ts is not affected.
//     - ev_valid=0 from the next cycle.
//   FSM: none beyond the FIFO. Full = level==DEPTH; empty = level==0.
//
// TESTING
//   1. Reset then single event: rst 1->0, detected pulse at ts=5 with ev_ready=1
//      -> next cycle ev_valid=1, ev_ts=5. Then ev_valid=0, event_count=1.
//   2. Backpressure/fill: ev_ready=0, 9 events at DEPTH=8
//      -> fifo_level=8, event_count=8, drop_count=1, overflow=1.
//      Then ev_ready=1 drains 8 timestamps in order.
//   3. Full with simultaneous pop: level=8, event and pop same cycle
//      -> level stays 8, drop_count unchanged, new ts is the tail entry.
//   4. Wrap: TS_W=4, event at ts=15 and next event at ts=0 -> ev_ts 15 then 0.
//      Saturation: CNT_W=2, 5 events -> event_count=3.
//   5. enable=0 with detected pulses -> no push, counts unchanged.
//      clear with 3 entries and an event in the same cycle -> level=0, counts=0,
//      overflow=0, ts still running.
//   6. Reset mid-drain (level=4, ev_ready=1) -> next cycle all outputs 0.
//      An event in the rst cycle is not captured.

Source files
------------

// File: rtl/detect_event_logger.sv
// Timestamps detector strobes against a free-running counter, buffers them in a
// small FIFO drained over valid/ready, and keeps saturating capture/drop totals.
module detect_event_logger #(
    parameter int unsigned TS_W  = 16,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     detected,
    input  logic                     enable,
    input  logic                     clear,
    output logic                     ev_valid,
    input  logic                     ev_ready,
    output logic [TS_W-1:0]          ev_ts,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic [CNT_W-1:0]         event_count,
    output logic [CNT_W-1:0]         drop_count,
    output logic                     overflow
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    logic [TS_W-1:0]  ts_q,          ts_d;
    logic [PTR_W-1:0] wr_ptr_q,      wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q,      rd_ptr_d;
    logic [LVL_W-1:0] level_q,       level_d;
    logic [TS_W-1:0]  mem_q [DEPTH];
    logic [TS_W-1:0]  mem_d [DEPTH];
    logic [CNT_W-1:0] event_count_q, event_count_d;
    logic [CNT_W-1:0] drop_count_q,  drop_count_d;
    logic             overflow_q,    overflow_d;
    logic             ev_valid_q,    ev_valid_d;
    logic [TS_W-1:0]  ev_ts_q,       ev_ts_d;

    logic ev_c, pop_c, full_c, push_c, drop_c;

    // Handshake qualifiers for the current cycle.
    always_comb begin
        ev_c   = detected & enable;
        pop_c  = ev_valid_q & ev_ready;
        full_c = (level_q == LVL_W'(DEPTH));
        push_c = ev_c & (~full_c | pop_c);
        drop_c = ev_c & full_c & ~pop_c;
    end

    // Next-state: FIFO bookkeeping, counters, and the registered head view.
    always_comb begin
        ts_d          = ts_q + TS_W'(1);
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        level_d       = level_q;
        mem_d         = mem_q;
        event_count_d = event_count_q;
        drop_count_d  = drop_count_q;
        overflow_d    = overflow_q;
        ev_valid_d    = 1'b0;
        ev_ts_d       = ev_ts_q;

        if (clear) begin
            wr_ptr_d      = '0;
            rd_ptr_d      = '0;
            level_d       = '0;
            event_count_d = '0;
            drop_count_d  = '0;
            overflow_d    = 1'b0;
        end else begin
            if (push_c) begin
                mem_d[wr_ptr_q] = ts_q;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
                if (event_count_q != {CNT_W{1'b1}}) begin
                    event_count_d = event_count_q + CNT_W'(1);
                end
            end
            if (drop_c) begin
                overflow_d = 1'b1;
                if (drop_count_q != {CNT_W{1'b1}}) begin
                    drop_count_d = drop_count_q + CNT_W'(1);
                end
            end
            if (pop_c) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push_c, pop_c})
                2'b10:   level_d = level_q + LVL_W'(1);
                2'b01:   level_d = level_q - LVL_W'(1);
                default: level_d = level_q;
            endcase
            ev_valid_d = (level_d != '0);
            // A push landing on the new head slot bypasses the array this cycle.
            if (push_c && (wr_ptr_q == rd_ptr_d)) begin
                ev_ts_d = ts_q;
            end else begin
                ev_ts_d = mem_q[rd_ptr_d];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ts_q          <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            level_q       <= '0;
            event_count_q <= '0;
            drop_count_q  <= '0;
            overflow_q    <= 1'b0;
            ev_valid_q    <= 1'b0;
            ev_ts_q       <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            ts_q          <= ts_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            level_q       <= level_d;
            event_count_q <= event_count_d;
            drop_count_q  <= drop_count_d;
            overflow_q    <= overflow_d;
            ev_valid_q    <= ev_valid_d;
            ev_ts_q       <= ev_ts_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    assign ev_valid    = ev_valid_q;
    assign ev_ts       = ev_ts_q;
    assign fifo_level  = level_q;
    assign event_count = event_count_q;
    assign drop_count  = drop_count_q;
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_detect_event_logger.sv
// Randomized scoreboard bench for detect_event_logger with a queue-based reference model.
module tb_detect_event_logger;

    localparam int TS_W  = 4;
    localparam int DEPTH = 8;
    localparam int CNT_W = 4;
    localparam int TS_MOD  = 1 << TS_W;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
    localparam int N_CYCLES = 4000;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   detected;
    logic                   enable;
    logic                   clear;
    logic                   ev_valid;
    logic                   ev_ready;
    logic [TS_W-1:0]        ev_ts;
    logic [$clog2(DEPTH):0] fifo_level;
    logic [CNT_W-1:0]       event_count;
    logic [CNT_W-1:0]       drop_count;
    logic                   overflow;

    detect_event_logger #(
        .TS_W (TS_W),
        .DEPTH(DEPTH),
        .CNT_W(CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .detected   (detected),
        .enable     (enable),
        .clear      (clear),
        .ev_valid   (ev_valid),
        .ev_ready   (ev_ready),
        .ev_ts      (ev_ts),
        .fifo_level (fifo_level),
        .event_count(event_count),
        .drop_count (drop_count),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    // Reference state: contents as a queue of timestamps plus plain integer totals.
    int m_ts = 0;
    int m_level = 0;
    int m_evc = 0;
    int m_drop = 0;
    int m_ovf = 0;
    int exp_q[$];

    int n_checks = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: advances on each edge from the inputs applied during that cycle.
    always @(posedge clk) begin
        bit ev, pop;
        if (rst) begin
            m_ts = 0; m_level = 0; m_evc = 0; m_drop = 0; m_ovf = 0;
            exp_q.delete();
        end else begin
            ev  = detected && enable;
            pop = (m_level > 0) && ev_ready;
            if (clear) begin
                m_level = 0; m_evc = 0; m_drop = 0; m_ovf = 0;
                exp_q.delete();
            end else begin
                if (ev && (m_level < DEPTH || pop)) begin
                    exp_q.push_back(m_ts);
                    m_level++;
                    if (m_evc < CNT_MAX) m_evc++;
                end else if (ev) begin
                    if (m_drop < CNT_MAX) m_drop++;
                    m_ovf = 1;
                end
                if (pop) m_level--;
            end
            m_ts = (m_ts + 1) % TS_MOD;
        end
    end

    // Monitor: compare status every cycle, check the head, retire it on a handshake.
    always @(negedge clk) begin
        check("ev_valid",    32'(ev_valid),    32'(m_level > 0));
        check("fifo_level",  32'(fifo_level),  32'(m_level));
        check("event_count", 32'(event_count), 32'(m_evc));
        check("drop_count",  32'(drop_count),  32'(m_drop));
        check("overflow",    32'(overflow),    32'(m_ovf));
        if (ev_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("ev_ts_unexpected", 32'(ev_ts), 32'hFFFF_FFFF);
            end else begin
                check("ev_ts", 32'(ev_ts), 32'(exp_q[0]));
                if (ev_ready && !rst && !clear) begin
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    // Stimulus: random phases of event density and backpressure, rare clear/reset.
    initial begin
        int det_pct, rdy_pct, en_pct;
        rst = 1'b1; detected = 1'b0; enable = 1'b0; clear = 1'b0; ev_ready = 1'b0;
        det_pct = 50; rdy_pct = 50; en_pct = 100;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        for (int cyc = 0; cyc < N_CYCLES; cyc++) begin
            @(posedge clk);
            #1;
            if (cyc % 48 == 0) begin
                case ($urandom_range(0, 3))
                    0: begin det_pct = 90;  rdy_pct = 0;   end
                    1: begin det_pct = 20;  rdy_pct = 100; end
                    2: begin det_pct = 100; rdy_pct = 40;  end
                    default: begin det_pct = 50; rdy_pct = 70; end
                endcase
                en_pct = ($urandom_range(0, 3) == 0) ? 60 : 100;
            end
            detected = ($urandom_range(0, 99) < det_pct);
            ev_ready = ($urandom_range(0, 99) < rdy_pct);
            enable   = ($urandom_range(0, 99) < en_pct);
            clear    = ($urandom_range(0, 99) < 2);
            rst      = ($urandom_range(0, 299) == 0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0; clear = 1'b0; detected = 1'b0; ev_ready = 1'b1;
        repeat (2 * DEPTH) @(posedge clk);
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
